// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write sequencer.
// Holds the FSM state encoding, the queued write request and the init-index stepping helper.
package regfile_pkg;

    localparam int unsigned RF_NUM_REGS   = 32;
    localparam int unsigned RF_DATA_WIDTH = 64;
    localparam int unsigned RF_ZERO_REG   = 31;
    localparam int unsigned REG_IDX_W     = 5;

    typedef enum logic [0:0] {
        SERVE = 1'b0,
        INIT  = 1'b1
    } seq_state_e;

    typedef struct packed {
        logic [REG_IDX_W-1:0]     reg_idx;
        logic [RF_DATA_WIDTH-1:0] data;
    } wr_req_t;

    // Next register to initialise; the hardwired-zero index costs no cycle.
    function automatic logic [REG_IDX_W-1:0] next_init_idx(
        input logic [REG_IDX_W-1:0] cur,
        input logic [REG_IDX_W-1:0] skip
    );
        logic [REG_IDX_W-1:0] nxt;
        nxt = cur + REG_IDX_W'(1);
        if (nxt == skip) begin
            nxt = nxt + REG_IDX_W'(1);
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/wr_req_fifo.sv
// Small synchronous FIFO of register write requests.
// Head entry is visible combinationally; push is refused when full, pop is refused when empty.
module wr_req_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     push,
    input  wr_req_t                  push_data,
    input  logic                     pop,
    output wr_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    wr_req_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == CNT_W'(0));
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally at a power-of-2 depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge Clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Owns the register-file write port: an init sweep over all writable registers,
// otherwise one queued upstream request per cycle. Write-port outputs are registered.
module regfile_write_sequencer
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS   = RF_NUM_REGS,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ZERO_REG   = RF_ZERO_REG
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  InitMode,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic [REG_IDX_W-1:0]  ReqReg,
    input  logic [DATA_WIDTH-1:0] ReqData,
    output logic [REG_IDX_W-1:0]  RW,
    output logic [DATA_WIDTH-1:0] BusW,
    output logic                  RegWr,
    output logic                  Busy,
    output logic                  Done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]     DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [REG_IDX_W-1:0] ZERO_IDX  = REG_IDX_W'(ZERO_REG);
    localparam logic [REG_IDX_W-1:0] FIRST_IDX = (ZERO_REG == 0) ? REG_IDX_W'(1) : REG_IDX_W'(0);
    localparam logic [REG_IDX_W-1:0] LAST_IDX  = (ZERO_REG == NUM_REGS - 1) ?
                                                 REG_IDX_W'(NUM_REGS - 2) : REG_IDX_W'(NUM_REGS - 1);

    seq_state_e             state_q, state_d;
    logic [REG_IDX_W-1:0]   cnt_q, cnt_d;
    logic                   mode_q, mode_d;
    logic [REG_IDX_W-1:0]   rw_q, rw_d;
    logic [DATA_WIDTH-1:0]  busw_q, busw_d;
    logic                   regwr_q, regwr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    wr_req_t                req_s;
    wr_req_t                head_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic [CNT_W-1:0]       fifo_count_s;

    assign req_s    = '{reg_idx: ReqReg, data: ReqData};
    assign push_s   = ReqValid && !fifo_full_s;
    assign ReqReady = (fifo_count_s < DEPTH_CNT);

    wr_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (push_s),
        .push_data (req_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Next-state and write-port selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        rw_d    = rw_q;
        busw_d  = busw_q;
        regwr_d = 1'b0;
        done_d  = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            SERVE: begin
                if (Start) begin
                    // Start wins over draining this cycle.
                    state_d = INIT;
                    mode_d  = InitMode;
                    cnt_d   = FIRST_IDX;
                end else if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    rw_d    = head_s.reg_idx;
                    busw_d  = head_s.data;
                    regwr_d = (head_s.reg_idx != ZERO_IDX);
                end else begin
                    regwr_d = 1'b0;
                end
            end
            INIT: begin
                rw_d    = cnt_q;
                busw_d  = mode_q ? {{(DATA_WIDTH-REG_IDX_W){1'b0}}, cnt_q} : '0;
                regwr_d = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = SERVE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = next_init_idx(cnt_q, ZERO_IDX);
                end
            end
            default: begin
                state_d = SERVE;
            end
        endcase
        busy_d = (state_d == INIT);
    end

    // State and registered write-port outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= SERVE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            rw_q    <= '0;
            busw_q  <= '0;
            regwr_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            rw_q    <= rw_d;
            busw_q  <= busw_d;
            regwr_q <= regwr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign RW    = rw_q;
    assign BusW  = busw_q;
    assign RegWr = regwr_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule
